// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects chain: dynamics FSM states,
// default sample width and the compressor/limiter mode encodings.
package audio_fx_pkg;

    localparam int DEFAULT_WIDTH = 12;

    localparam logic MODE_COMP  = 1'b0;
    localparam logic MODE_LIMIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENV,
        ST_APPLY,
        ST_DONE
    } dyn_state_t;

endpackage

// File: rtl/envelope_follower.sv
// Combinational next-envelope step (attack/release by right shift).
// With DYNPROC_PEAK_HOLD_EN defined, a hold counter freezes release after a rise.
module envelope_follower
    import audio_fx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DYNPROC_PEAK_HOLD_EN
    ,
    parameter int HOLD_SAMPLES = 4,
    parameter int HOLD_W       = $clog2(HOLD_SAMPLES + 1)
`endif
) (
    input  logic [WIDTH-2:0]  mag,
    input  logic [WIDTH-2:0]  env,
    input  logic [3:0]        attack_shift,
    input  logic [3:0]        release_shift,
`ifdef DYNPROC_PEAK_HOLD_EN
    input  logic [HOLD_W-1:0] hold,
    output logic [HOLD_W-1:0] hold_next,
`endif
    output logic [WIDTH-2:0]  env_next
);

    logic rise;

    always_comb begin
        env_next = env;
        rise     = (mag > env);
`ifdef DYNPROC_PEAK_HOLD_EN
        hold_next = hold;
        if (rise) begin
            env_next  = env + ((mag - env) >> attack_shift);
            hold_next = HOLD_W'(HOLD_SAMPLES);
        end else if (hold != '0) begin
            // Peak hold: keep the envelope and count the hold down
            hold_next = hold - HOLD_W'(1);
        end else begin
            env_next = env - ((env - mag) >> release_shift);
        end
`else
        if (rise) begin
            env_next = env + ((mag - env) >> attack_shift);
        end else begin
            env_next = env - ((env - mag) >> release_shift);
        end
`endif
    end

endmodule

// File: rtl/dynamics_processor.sv
// Time-multiplexed multi-channel compressor / hard limiter with per-channel envelopes.
// Optional peak hold on the envelope release when DYNPROC_PEAK_HOLD_EN is defined.
module dynamics_processor
    import audio_fx_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CHANNELS     = 2,
    parameter int HOLD_SAMPLES = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         new_sample_ready,
    input  logic [CHANNELS*WIDTH-1:0]    samples_in,
    input  logic                         bypass,
    input  logic                         mode,
    input  logic [WIDTH-2:0]             threshold,
    input  logic [2:0]                   ratio_shift,
    input  logic [3:0]                   attack_shift,
    input  logic [3:0]                   release_shift,
    output logic [CHANNELS*WIDTH-1:0]    samples_out,
    output logic                         sample_ready,
    output logic                         overrun
);

    localparam int MAG_W = WIDTH - 1;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DYNPROC_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
`endif

    if (CHANNELS < 1 || HOLD_SAMPLES < 1) begin : g_bad_param
        $error("dynamics_processor: CHANNELS and HOLD_SAMPLES must be >= 1");
    end

    function automatic logic [MAG_W-1:0] mag_sat(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] neg;
        neg = -x;
        if (x == MOST_NEG)
            return '1;
        else if (x[WIDTH-1])
            return neg[MAG_W-1:0];
        else
            return x[MAG_W-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] restore_sign(input logic negative,
                                                             input logic [MAG_W-1:0] m);
        if (negative)
            return -$signed({1'b0, m});
        else
            return $signed({1'b0, m});
    endfunction

    dyn_state_t state, state_next;
    logic [IDX_W-1:0] idx;
    logic [MAG_W-1:0] env_q [CHANNELS];
`ifdef DYNPROC_PEAK_HOLD_EN
    logic [HOLD_W-1:0] hold_q [CHANNELS];
    logic [HOLD_W-1:0] hold_next;
`endif

    // Capture stage: frame samples and configuration, held for the whole frame
    logic signed [WIDTH-1:0] x_p0 [CHANNELS];
    logic                    byp_p0;
    logic                    mode_p0;
    logic [MAG_W-1:0]        thr_p0;
    logic [2:0]              ratio_p0;
    logic [3:0]              atk_p0;
    logic [3:0]              rel_p0;
    logic signed [WIDTH-1:0] out_buf_p1 [CHANNELS];

    logic signed [WIDTH-1:0]      x_cur;
    logic [MAG_W-1:0]             mag_cur;
    logic [MAG_W-1:0]             env_cur;
    logic [MAG_W-1:0]             env_next;
    logic [MAG_W-1:0]             over;
    logic [MAG_W-1:0]             red;
    logic [MAG_W-1:0]             out_mag;
    logic signed [WIDTH-1:0]      out_cur;
    logic [CHANNELS*WIDTH-1:0]    out_packed;
    logic                         last_ch;

    assign x_cur   = x_p0[idx];
    assign mag_cur = mag_sat(x_cur);
    assign env_cur = env_q[idx];
    assign last_ch = (idx == IDX_W'(CHANNELS - 1));

    envelope_follower #(
        .WIDTH        (WIDTH)
`ifdef DYNPROC_PEAK_HOLD_EN
        ,
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .HOLD_W       (HOLD_W)
`endif
    ) u_env (
        .mag           (mag_cur),
        .env           (env_cur),
        .attack_shift  (atk_p0),
        .release_shift (rel_p0),
`ifdef DYNPROC_PEAK_HOLD_EN
        .hold          (hold_q[idx]),
        .hold_next     (hold_next),
`endif
        .env_next      (env_next)
    );

    // Gain stage: uses the envelope written during the preceding ENV cycle
    always_comb begin
        over    = (env_cur > thr_p0) ? (env_cur - thr_p0) : '0;
        red     = over - (over >> ratio_p0);
        out_mag = (mag_cur > red) ? (mag_cur - red) : '0;
        if (mode_p0 == MODE_LIMIT)
            out_mag = (mag_cur < thr_p0) ? mag_cur : thr_p0;
        out_cur = byp_p0 ? x_cur : restore_sign(x_cur[WIDTH-1], out_mag);
    end

    always_comb begin
        out_packed = '0;
        for (int k = 0; k < CHANNELS; k++)
            out_packed[k*WIDTH +: WIDTH] = (k == CHANNELS - 1) ? out_cur : out_buf_p1[k];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (new_sample_ready) state_next = ST_ENV;
            ST_ENV:   state_next = ST_APPLY;
            ST_APPLY: state_next = last_ch ? ST_DONE : ST_ENV;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            overrun      <= 1'b0;
            sample_ready <= 1'b0;
            samples_out  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                env_q[k] <= '0;
`ifdef DYNPROC_PEAK_HOLD_EN
                hold_q[k] <= '0;
`endif
            end
        end else begin
            state        <= state_next;
            sample_ready <= 1'b0;
            if (new_sample_ready && state != ST_IDLE)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: if (new_sample_ready) idx <= '0;
                ST_ENV: begin
                    env_q[idx] <= env_next;
`ifdef DYNPROC_PEAK_HOLD_EN
                    hold_q[idx] <= hold_next;
`endif
                end
                ST_APPLY: begin
                    if (last_ch) begin
                        samples_out  <= out_packed;
                        sample_ready <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == ST_IDLE && new_sample_ready) begin
            for (int k = 0; k < CHANNELS; k++)
                x_p0[k] <= samples_in[k*WIDTH +: WIDTH];
            byp_p0   <= bypass;
            mode_p0  <= mode;
            thr_p0   <= threshold;
            ratio_p0 <= ratio_shift;
            atk_p0   <= attack_shift;
            rel_p0   <= release_shift;
        end
        if (state == ST_APPLY)
            out_buf_p1[idx] <= out_cur;
    end

endmodule

// File: tb/tb_dynamics_processor.sv
// Self-checking bench for dynamics_processor (WIDTH=12, CHANNELS=2): scoreboard of
// expected frames from a behavioural envelope/gain model, plus directed scenarios.
module tb_dynamics_processor;

    localparam int W    = 12;
    localparam int CH   = 2;
    localparam int HOLD = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              new_sample_ready;
    logic [CH*W-1:0]   samples_in;
    logic              bypass;
    logic              mode;
    logic [W-2:0]      threshold;
    logic [2:0]        ratio_shift;
    logic [3:0]        attack_shift;
    logic [3:0]        release_shift;
    logic [CH*W-1:0]   samples_out;
    logic              sample_ready;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    logic [CH*W-1:0] exp_q[$];
    int env_m  [CH];
    int hold_m [CH];

    always #5 clock = ~clock;

    dynamics_processor #(
        .WIDTH        (W),
        .CHANNELS     (CH),
        .HOLD_SAMPLES (HOLD)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .new_sample_ready (new_sample_ready),
        .samples_in       (samples_in),
        .bypass           (bypass),
        .mode             (mode),
        .threshold        (threshold),
        .ratio_shift      (ratio_shift),
        .attack_shift     (attack_shift),
        .release_shift    (release_shift),
        .samples_out      (samples_out),
        .sample_ready     (sample_ready),
        .overrun          (overrun)
    );

    function automatic logic [CH*W-1:0] pack2(input int c0, input int c1);
        logic [W-1:0] a, b;
        a = W'(c0);
        b = W'(c1);
        return {b, a};
    endfunction

    // Behavioural reference: updates the model envelopes and returns the expected frame
    function automatic logic [CH*W-1:0] model_frame(input logic [CH*W-1:0] s);
        logic [CH*W-1:0]     res;
        logic signed [W-1:0] xs;
        logic [W-1:0]        o;
        int x, mag, over, rr, om, thr;
        res = '0;
        thr = int'(threshold);
        for (int k = 0; k < CH; k++) begin
            xs  = s[k*W +: W];
            x   = int'(xs);
            mag = (x < 0) ? -x : x;
            if (mag > 2047) mag = 2047;
            if (mag > env_m[k]) begin
                env_m[k]  = env_m[k] + ((mag - env_m[k]) >> attack_shift);
                hold_m[k] = HOLD;
            end else begin
`ifdef DYNPROC_PEAK_HOLD_EN
                if (hold_m[k] > 0) hold_m[k] = hold_m[k] - 1;
                else
`endif
                env_m[k] = env_m[k] - ((env_m[k] - mag) >> release_shift);
            end
            if (mode) begin
                om = (mag < thr) ? mag : thr;
            end else begin
                over = (env_m[k] > thr) ? env_m[k] - thr : 0;
                rr   = over - (over >> ratio_shift);
                om   = (mag > rr) ? mag - rr : 0;
            end
            if (bypass) o = W'(x);
            else        o = (x < 0) ? W'(-om) : W'(om);
            res[k*W +: W] = o;
        end
        return res;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < CH; k++) begin
            env_m[k]  = 0;
            hold_m[k] = 0;
        end
    endtask

    task automatic set_cfg(input logic byp, input logic md, input int thr,
                           input int rs, input int as, input int ls);
        bypass        = byp;
        mode          = md;
        threshold     = (W-1)'(thr);
        ratio_shift   = 3'(rs);
        attack_shift  = 4'(as);
        release_shift = 4'(ls);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        new_sample_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        reset_model();
    endtask

    // Strobe one frame, push its expectation, wait (bounded) for sample_ready
    task automatic send_frame(input logic [CH*W-1:0] s, output int cyc, output bit seen);
        @(negedge clock);
        samples_in       = s;
        new_sample_ready = 1'b1;
        exp_q.push_back(model_frame(s));
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(negedge clock);
            new_sample_ready = 1'b0;
            cyc++;
            if (sample_ready) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [CH*W-1:0] e;
        set_cfg(0, 0, 0, 0, 0, 0);
        samples_in = '0;
        do_reset();
        e = '0;
        checks++;
        if (samples_out !== e) begin
            failures++;
            $display("FAIL reset_samples_out got=%h want=%h", samples_out, e);
        end
        checks++;
        if (sample_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_sample_ready got=%b want=0", sample_ready);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_overrun got=%b want=0", overrun);
        end
    endtask

    task automatic test_passthrough();
        int cyc; bit seen; logic [CH*W-1:0] e;
        set_cfg(0, 0, 1000, 1, 0, 0);
        send_frame(pack2(500, 500), cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || cyc !== 5) begin
            failures++;
            $display("FAIL pass_latency got=%0d seen=%0b want=5", cyc, seen);
        end
        checks++;
        if (samples_out !== e) begin
            failures++;
            $display("FAIL pass_data got=%h want=%h", samples_out, e);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (sample_ready !== 1'b0 || samples_out !== e) begin
            failures++;
            $display("FAIL pass_hold got=%h rdy=%b want=%h rdy=0", samples_out, sample_ready, e);
        end
    endtask

    task automatic test_limiter();
        int cyc; bit seen; logic [CH*W-1:0] e, c;
        set_cfg(0, 1, 1000, 0, 0, 0);
        send_frame(pack2(-2048, 1500), cyc, seen);
        e = exp_q.pop_front();
        c = pack2(-1000, 1000);
        checks++;
        if (!seen || samples_out !== e) begin
            failures++;
            $display("FAIL limiter_model got=%h seen=%0b want=%h", samples_out, seen, e);
        end
        checks++;
        if (samples_out !== c) begin
            failures++;
            $display("FAIL limiter_const got=%h want=%h", samples_out, c);
        end
    endtask

    task automatic test_compression();
        int cyc; bit seen; logic [CH*W-1:0] e;
        do_reset();
        set_cfg(0, 0, 1024, 1, 0, 2);
        send_frame(pack2(1800, 0), cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || samples_out !== e) begin
            failures++;
            $display("FAIL comp_model got=%h seen=%0b want=%h", samples_out, seen, e);
        end
        checks++;
        if (samples_out[W-1:0] !== 12'd1412) begin
            failures++;
            $display("FAIL comp_const got=%0d want=1412", samples_out[W-1:0]);
        end
    endtask

    // Envelope is not an output; a max-level probe with slow attack exposes it via the gain
    task automatic test_release();
        int cyc; bit seen; logic [CH*W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            set_cfg(0, 0, 1024, 1, 0, 2);
            send_frame(pack2(0, 0), cyc, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen || samples_out !== e) begin
                failures++;
                $display("FAIL release_frame%0d got=%h want=%h", i, samples_out, e);
            end
        end
        set_cfg(0, 0, 0, 7, 15, 2);
        send_frame(pack2(2047, 2047), cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || samples_out !== e) begin
            failures++;
            $display("FAIL release_probe got=%h want=%h", samples_out, e);
        end
        checks++;
`ifdef DYNPROC_PEAK_HOLD_EN
        if (samples_out[W-1:0] !== 12'd261) begin
            failures++;
            $display("FAIL release_probe_const got=%0d want=261", samples_out[W-1:0]);
        end
`else
        if (samples_out[W-1:0] !== 12'd1041) begin
            failures++;
            $display("FAIL release_probe_const got=%0d want=1041", samples_out[W-1:0]);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            set_cfg(0, 0, 0, 7, 15, 1);
            send_frame((i == 5) ? pack2(2047, -2047) : pack2(3, -5), cyc, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen || samples_out !== e) begin
                failures++;
                $display("FAIL release_tail%0d got=%h want=%h", i, samples_out, e);
            end
        end
    endtask

    task automatic test_overrun();
        int cyc, pulses, lat; logic [CH*W-1:0] e;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_pre got=%b want=0", overrun);
        end
        set_cfg(0, 0, 300, 2, 1, 3);
        @(negedge clock);
        samples_in       = pack2(-900, 700);
        new_sample_ready = 1'b1;
        exp_q.push_back(model_frame(samples_in));
        pulses = 0; lat = 0;
        for (cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clock);
            new_sample_ready = 1'b0;
            if (cyc == 2) begin
                samples_in       = pack2(100, -100);
                new_sample_ready = 1'b1;
            end
            if (sample_ready) begin
                pulses++;
                if (lat == 0) lat = cyc;
                if (pulses == 1) e = samples_out;
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag got=%b want=1", overrun);
        end
        checks++;
        if (pulses !== 1 || lat !== 5) begin
            failures++;
            $display("FAIL overrun_pulses got=%0d lat=%0d want=1 lat=5", pulses, lat);
        end
        begin
            logic [CH*W-1:0] x;
            x = exp_q.pop_front();
            checks++;
            if (e !== x) begin
                failures++;
                $display("FAIL overrun_data got=%h want=%h", e, x);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int cyc, pulses; bit seen; logic [CH*W-1:0] e;
        set_cfg(0, 0, 50, 1, 0, 0);
        @(negedge clock);
        samples_in       = pack2(1500, -1500);
        new_sample_ready = 1'b1;
        for (cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clock);
            new_sample_ready = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (samples_out !== '0 || sample_ready !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h rdy=%b ovr=%b want=0", samples_out, sample_ready, overrun);
        end
        @(negedge clock);
        reset_n = 1'b1;
        reset_model();
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (sample_ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midreset_no_ready got=%0d want=0", pulses);
        end
        set_cfg(0, 0, 100, 2, 1, 0);
        send_frame(pack2(800, -600), cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || samples_out !== e) begin
            failures++;
            $display("FAIL midreset_next got=%h seen=%0b want=%h", samples_out, seen, e);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; logic [CH*W-1:0] e;
        for (int i = 0; i < 16; i++) begin
            set_cfg(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2047), $urandom_range(0, 7),
                    $urandom_range(0, 15), $urandom_range(0, 15));
            send_frame(pack2($urandom_range(0, 4095), (i == 3) ? 2048 : $urandom_range(0, 4095)),
                       cyc, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen || cyc !== 5 || samples_out !== e) begin
                failures++;
                $display("FAIL b2b_%0d got=%h lat=%0d want=%h lat=5", i, samples_out, cyc, e);
            end
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        new_sample_ready = 1'b0;
        samples_in       = '0;
        reset_model();
        test_reset();
        test_passthrough();
        test_limiter();
        test_compression();
        test_release();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
